// File: rtl/cart_bus_responder_pkg.sv
// Shared types and bus widths for the cartridge-side CPU bus responder.
package cart_bus_pkg;

    localparam int CPU_ADDR_W = 15;
    localparam int CPU_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        READ,
        DRIVE,
        WRITE_CAP,
        WRITE_REQ,
        WAIT_LOW
    } state_t;

endpackage

// File: rtl/cart_bus_responder_if.sv
// CPU bus strobes/data plus the local byte-memory request port.
interface cart_bus_if;
    import cart_bus_pkg::*;

    logic                  m2;
    logic                  romsel;
    logic                  cpu_rw;
    logic [CPU_ADDR_W-1:0] cpu_addr;
    logic [CPU_DATA_W-1:0] cpu_data_in;
    logic [CPU_DATA_W-1:0] cpu_data_out;
    logic                  cpu_data_oe;
    logic [CPU_ADDR_W-1:0] mem_addr;
    logic [CPU_DATA_W-1:0] mem_wdata;
    logic                  mem_rd_req;
    logic                  mem_wr_req;
    logic [CPU_DATA_W-1:0] mem_rdata;
    logic                  mem_ack;

    modport master (
        output m2, romsel, cpu_rw, cpu_addr, cpu_data_in, mem_rdata, mem_ack,
        input  cpu_data_out, cpu_data_oe, mem_addr, mem_wdata, mem_rd_req, mem_wr_req
    );

    modport slave (
        input  m2, romsel, cpu_rw, cpu_addr, cpu_data_in, mem_rdata, mem_ack,
        output cpu_data_out, cpu_data_oe, mem_addr, mem_wdata, mem_rd_req, mem_wr_req
    );

endinterface

// File: rtl/cart_bus_responder_bus_sync.sv
// Multi-stage synchroniser for asynchronous bus inputs, with edge detect on the
// synchronised output.
module bus_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] sync_r [STAGES];
    logic [WIDTH-1:0] q_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) sync_r[i] <= '0;
            q_prev <= '0;
        end else begin
            sync_r[0] <= d;
            for (int i = 1; i < STAGES; i++) sync_r[i] <= sync_r[i-1];
            q_prev <= sync_r[STAGES-1];
        end
    end

    assign q    = sync_r[STAGES-1];
    assign rise = q & ~q_prev;
    assign fall = ~q & q_prev;

endmodule

// File: rtl/cart_bus_responder.sv
// Decodes Famicom CPU bus cycles at $8000-$FFFF and converts each one into a
// single request on a local byte-memory port; read data is driven back until M2 falls.
module cart_bus_responder
    import cart_bus_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_CYCLES  = 3,
    parameter int HOLD_CYCLES    = 1,
    parameter int MISS_CNT_WIDTH = 8
) (
    input  logic                      master_clock,
    input  logic                      reset,
    cart_bus_if.slave                 bus,
    output logic [MISS_CNT_WIDTH-1:0] miss_count,
    output logic                      busy
);

    localparam int CNT_MAX = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic m2_s, m2_rise, m2_fall, romsel_s, rw_s;
    logic [CPU_DATA_W-1:0] data_s;
    logic unused_romsel_rise, unused_romsel_fall, unused_rw_rise, unused_rw_fall;
    logic [CPU_DATA_W-1:0] unused_data_rise, unused_data_fall;

    bus_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_m2_sync (
        .clk(master_clock), .rst(reset), .d(bus.m2),
        .q(m2_s), .rise(m2_rise), .fall(m2_fall));
    bus_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_romsel_sync (
        .clk(master_clock), .rst(reset), .d(bus.romsel),
        .q(romsel_s), .rise(unused_romsel_rise), .fall(unused_romsel_fall));
    bus_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_rw_sync (
        .clk(master_clock), .rst(reset), .d(bus.cpu_rw),
        .q(rw_s), .rise(unused_rw_rise), .fall(unused_rw_fall));
    bus_sync #(.WIDTH(CPU_DATA_W), .STAGES(SYNC_STAGES)) u_data_sync (
        .clk(master_clock), .rst(reset), .d(bus.cpu_data_in),
        .q(data_s), .rise(unused_data_rise), .fall(unused_data_fall));

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic                  fell, fell_n;
    logic                  oe_r, oe_n, rd_r, rd_n, wr_r, wr_n;
    logic [CPU_DATA_W-1:0] dout_r, dout_n, wdata_r, wdata_n;
    logic [CPU_ADDR_W-1:0] addr_r, addr_n;
    logic [1:0]            miss_add;
    logic [MISS_CNT_WIDTH-1:0] miss_r;

    function automatic logic [MISS_CNT_WIDTH-1:0] sat_add(
        input logic [MISS_CNT_WIDTH-1:0] c, input logic [1:0] a);
        logic [MISS_CNT_WIDTH:0] s;
        s = {1'b0, c} + (MISS_CNT_WIDTH+1)'(a);
        return s[MISS_CNT_WIDTH] ? '1 : s[MISS_CNT_WIDTH-1:0];
    endfunction

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        fell_n   = fell;
        oe_n     = oe_r;
        dout_n   = dout_r;
        addr_n   = addr_r;
        wdata_n  = wdata_r;
        rd_n     = rd_r;
        wr_n     = wr_r;
        miss_add = 2'd0;
        // A new M2 cycle arriving while one is still in flight is lost.
        if (m2_rise && state != IDLE && state != WAIT_LOW) miss_add = miss_add + 2'd1;
        case (state)
            IDLE: if (m2_rise) begin
                state_n = SETTLE;
                cnt_n   = CNT_W'(SETTLE_CYCLES - 1);
            end
            SETTLE: if (m2_fall) begin
                miss_add = miss_add + 2'd1;
                state_n  = IDLE;
            end else if (cnt == '0) begin
                if (romsel_s) state_n = WAIT_LOW;
                else begin
                    addr_n = bus.cpu_addr;
                    fell_n = 1'b0;
                    if (rw_s) begin
                        rd_n    = 1'b1;
                        state_n = READ;
                    end else state_n = WRITE_CAP;
                end
            end else cnt_n = cnt - CNT_W'(1);
            READ: begin
                if (m2_fall) fell_n = 1'b1;
                // The request is always completed, even if the CPU has already moved on.
                if (bus.mem_ack) begin
                    rd_n = 1'b0;
                    if (m2_s && !fell) begin
                        dout_n  = bus.mem_rdata;
                        oe_n    = 1'b1;
                        fell_n  = 1'b0;
                        state_n = DRIVE;
                    end else begin
                        miss_add = miss_add + 2'd1;
                        state_n  = IDLE;
                    end
                end
            end
            DRIVE: if (fell) begin
                if (cnt == '0) begin
                    oe_n    = 1'b0;
                    state_n = IDLE;
                end else cnt_n = cnt - CNT_W'(1);
            end else if (m2_fall) begin
                if (HOLD_CYCLES == 0) begin
                    oe_n    = 1'b0;
                    state_n = IDLE;
                end else begin
                    fell_n = 1'b1;
                    cnt_n  = CNT_W'(HOLD_CYCLES - 1);
                end
            end
            WRITE_CAP: if (m2_s) wdata_n = data_s;
            else begin
                wr_n    = 1'b1;
                state_n = WRITE_REQ;
            end
            WRITE_REQ: if (bus.mem_ack) begin
                wr_n    = 1'b0;
                state_n = IDLE;
            end
            WAIT_LOW: if (!m2_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge master_clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            fell    <= 1'b0;
            oe_r    <= 1'b0;
            dout_r  <= '0;
            addr_r  <= '0;
            wdata_r <= '0;
            rd_r    <= 1'b0;
            wr_r    <= 1'b0;
            miss_r  <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            fell    <= fell_n;
            oe_r    <= oe_n;
            dout_r  <= dout_n;
            addr_r  <= addr_n;
            wdata_r <= wdata_n;
            rd_r    <= rd_n;
            wr_r    <= wr_n;
            miss_r  <= sat_add(miss_r, miss_add);
        end
    end

    assign bus.cpu_data_out = dout_r;
    assign bus.cpu_data_oe  = oe_r;
    assign bus.mem_addr     = addr_r;
    assign bus.mem_wdata    = wdata_r;
    assign bus.mem_rd_req   = rd_r;
    assign bus.mem_wr_req   = wr_r;
    assign miss_count       = miss_r;
    assign busy             = (state != IDLE);

endmodule

// File: tb/tb_cart_bus_responder.sv
// Bench for cart_bus_responder: table of CPU bus cycles with a memory model and
// an event scoreboard, plus a hand-written reset-during-write sequence.
module tb_cart_bus_responder;
    import cart_bus_pkg::*;

    localparam int SYNC   = 2;
    localparam int SETTLE = 3;
    localparam int HOLD   = 1;
    localparam int MW     = 2;

    localparam logic [1:0] K_RD  = 2'd1;
    localparam logic [1:0] K_WR  = 2'd2;
    localparam logic [1:0] K_DRV = 2'd3;

    logic clk = 1'b0;
    logic reset;
    logic [MW-1:0] miss_count;
    logic busy;

    cart_bus_if bus();

    cart_bus_responder #(
        .SYNC_STAGES(SYNC), .SETTLE_CYCLES(SETTLE),
        .HOLD_CYCLES(HOLD), .MISS_CNT_WIDTH(MW)
    ) dut (
        .master_clock(clk), .reset(reset), .bus(bus),
        .miss_count(miss_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: ack ack_dly cycles after a request first appears.
    int ack_dly;
    int mcnt;
    logic [7:0] tb_rdata;
    always @(posedge clk) begin
        if (reset) begin
            bus.mem_ack <= 1'b0;
            mcnt        <= 0;
        end else if (bus.mem_ack) begin
            bus.mem_ack <= 1'b0;
            mcnt        <= 0;
        end else if (bus.mem_rd_req || bus.mem_wr_req) begin
            if (mcnt == ack_dly - 1) bus.mem_ack <= 1'b1;
            else mcnt <= mcnt + 1;
        end
    end
    assign bus.mem_rdata = tb_rdata;

    typedef struct packed {
        logic [1:0]  kind;
        logic [14:0] addr;
        logic [7:0]  data;
    } ev_t;

    typedef struct {
        logic        romsel;
        logic        rw;
        logic [14:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int          high;
        int          low;
        int          dly;
        bit          drive;
        int          miss;
        bit          rst;
    } vec_t;

    ev_t  exp_q[$];
    ev_t  last_wr;
    vec_t vecs[11];
    int   tests, fails;
    logic prev_rd, prev_wr, prev_oe;
    int   rd_rise_cyc, wr_rise_cyc, oe_rise_cyc, oe_fall_cyc, m2_rise_cyc, m2_fall_cyc;
    bit   busy_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        ev_t e;
        @(negedge clk);
        if (busy) busy_seen = 1'b1;
        if (bus.mem_rd_req && !prev_rd) begin
            rd_rise_cyc = cyc;
            check("rd_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rd_kind", e.kind, K_RD);
                check("rd_addr", bus.mem_addr, e.addr);
            end
        end
        if (bus.mem_wr_req && !prev_wr) begin
            wr_rise_cyc = cyc;
            check("wr_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                last_wr = e;
                check("wr_kind", e.kind, K_WR);
                check("wr_addr", bus.mem_addr, e.addr);
                check("wr_data", bus.mem_wdata, e.data);
            end
        end
        if (bus.cpu_data_oe && !prev_oe) begin
            oe_rise_cyc = cyc;
            check("drv_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("drv_kind", e.kind, K_DRV);
                check("drv_data", bus.cpu_data_out, e.data);
            end
        end
        if (!bus.cpu_data_oe && prev_oe) oe_fall_cyc = cyc;
        if (bus.mem_ack === 1'b1) begin
            check("req_excl", bus.mem_rd_req & bus.mem_wr_req, 0);
            if (bus.mem_wr_req) begin
                check("wr_hold_addr", bus.mem_addr, last_wr.addr);
                check("wr_hold_data", bus.mem_wdata, last_wr.data);
            end
        end
        prev_rd = bus.mem_rd_req;
        prev_wr = bus.mem_wr_req;
        prev_oe = bus.cpu_data_oe;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_oe"},    bus.cpu_data_oe, 0);
        check({tag, "_dout"},  bus.cpu_data_out, 0);
        check({tag, "_addr"},  bus.mem_addr, 0);
        check({tag, "_wdata"}, bus.mem_wdata, 0);
        check({tag, "_rdreq"}, bus.mem_rd_req, 0);
        check({tag, "_wrreq"}, bus.mem_wr_req, 0);
        check({tag, "_miss"},  miss_count, 0);
        check({tag, "_busy"},  busy, 0);
    endtask

    task automatic run_cycle(input vec_t v);
        rd_rise_cyc = -1; wr_rise_cyc = -1; oe_rise_cyc = -1; oe_fall_cyc = -1;
        busy_seen = 1'b0;
        tb_rdata        = v.rdata;
        ack_dly         = v.dly;
        bus.romsel      = v.romsel;
        bus.cpu_rw      = v.rw;
        bus.cpu_addr    = v.addr;
        bus.cpu_data_in = v.wdata;
        if (!v.romsel) begin
            if (v.rw) begin
                exp_q.push_back('{kind: K_RD, addr: v.addr, data: 8'h00});
                if (v.drive) exp_q.push_back('{kind: K_DRV, addr: v.addr, data: v.rdata});
            end else begin
                exp_q.push_back('{kind: K_WR, addr: v.addr, data: v.wdata});
            end
        end
        tick();
        tick();
        m2_rise_cyc = cyc;
        bus.m2 = 1'b1;
        repeat (v.high) tick();
        m2_fall_cyc = cyc;
        bus.m2 = 1'b0;
        bus.cpu_data_in = 8'hFF;
        repeat (v.low) tick();
        bus.romsel = 1'b1;
    endtask

    task automatic post_checks(input string tag, input vec_t v);
        check({tag, "_miss"},      miss_count, v.miss);
        check({tag, "_busy_end"},  busy, 0);
        check({tag, "_busy_seen"}, busy_seen, 1);
        check({tag, "_q_empty"},   exp_q.size(), 0);
        if (v.drive) begin
            check({tag, "_rd_lat"},  rd_rise_cyc - m2_rise_cyc, SYNC + SETTLE + 1);
            check({tag, "_oe_lat"},  oe_rise_cyc - rd_rise_cyc, v.dly + 1);
            check({tag, "_oe_hold"}, oe_fall_cyc - m2_fall_cyc, SYNC + HOLD + 1);
        end else begin
            check({tag, "_oe_never"}, oe_rise_cyc, -1);
        end
        if (!v.romsel && !v.rw)
            check({tag, "_wr_lat"}, wr_rise_cyc - m2_fall_cyc, SYNC + 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t g;
        bit   seen;
        tests = 0; fails = 0;
        reset = 1'b1;
        bus.m2 = 1'b0; bus.romsel = 1'b1; bus.cpu_rw = 1'b1;
        bus.cpu_addr = '0; bus.cpu_data_in = '0;
        tb_rdata = 8'h00; ack_dly = 1;
        prev_rd = 1'b0; prev_wr = 1'b0; prev_oe = 1'b0;

        //          romsel rw    addr      wdata  rdata  hi  lo  dly drive miss rst
        vecs[0]  = '{1'b0, 1'b1, 15'h1234, 8'h00, 8'hA5, 16, 12,  2, 1'b1, 0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 15'h7FFF, 8'h3C, 8'h00, 16, 12,  2, 1'b0, 0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 15'h0100, 8'h00, 8'h77, 16, 12,  2, 1'b0, 0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 15'h0ABC, 8'h00, 8'h5A, 12, 12,  1, 1'b1, 0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 15'h0000, 8'hC3, 8'h00, 10, 14,  5, 1'b0, 0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 15'h2222, 8'h00, 8'h11, 10, 25, 20, 1'b0, 1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 15'h2222, 8'h00, 8'h11, 10, 25, 20, 1'b0, 1, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 15'h2223, 8'h00, 8'h12, 10, 25, 20, 1'b0, 2, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 15'h2224, 8'h00, 8'h13, 10, 25, 20, 1'b0, 3, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 15'h2225, 8'h00, 8'h14, 10, 25, 20, 1'b0, 3, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 15'h2226, 8'h00, 8'h15, 10, 25, 20, 1'b0, 3, 1'b0};

        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_all_zero("reset");

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].rst) do_reset();
            run_cycle(vecs[i]);
            post_checks($sformatf("v%0d", i), vecs[i]);
        end

        // Reset while a write request is outstanding, then a normal read.
        do_reset();
        ack_dly = 40;
        bus.romsel = 1'b0; bus.cpu_rw = 1'b0;
        bus.cpu_addr = 15'h0155; bus.cpu_data_in = 8'h99;
        exp_q.push_back('{kind: K_WR, addr: 15'h0155, data: 8'h99});
        tick();
        tick();
        bus.m2 = 1'b1;
        repeat (8) tick();
        bus.m2 = 1'b0;
        bus.cpu_data_in = 8'hFF;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            seen = bus.mem_wr_req;
        end
        check("rst_wrreq_seen", seen, 1);
        reset = 1'b1;
        bus.romsel = 1'b1;
        tick();
        check_all_zero("rst_mid");
        reset = 1'b0;
        tick();
        check("rst_q_empty", exp_q.size(), 0);

        g = '{1'b0, 1'b1, 15'h4321, 8'h00, 8'h6E, 16, 12, 3, 1'b1, 0, 1'b0};
        run_cycle(g);
        post_checks("after_rst", g);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cart_bus_responder.md
Name: cart_bus_responder

Overview:
- Cartridge-side responder for the Famicom CPU bus cycles (M2, /ROMSEL, CPU R/W) produced by the dumper's FSMC bridge.
- Runs on master_clock. Synchronises the bus strobes and decodes each M2 cycle that targets $8000-$FFFF.
- Turns each decoded cycle into a single read or write request on a local byte-memory port, with an ack handshake.
- For reads, drives the returned byte onto the CPU data bus until M2 falls.
- Used for cartridge emulation and for loopback self-test of the dumper hardware.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on m2, romsel, cpu_rw and cpu_data_in (minimum 2).
- SETTLE_CYCLES, 3: master_clock cycles after synchronised M2 rise before address and R/W are sampled (minimum 1).
- HOLD_CYCLES, 1: cycles cpu_data_oe stays high after synchronised M2 fall.
- MISS_CNT_WIDTH, 8: width of the saturating missed-cycle counter.

Ports:
- master_clock  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- m2  in  1  CPU phi2, asynchronous.
- romsel  in  1  /ROMSEL, active-low, asynchronous.
- cpu_rw  in  1  1=read, 0=write, asynchronous.
- cpu_addr  in  15  A14..A0; sampled directly, stable by end of SETTLE.
- cpu_data_in  in  8  CPU data bus, input side.
- cpu_data_out  out  8  byte to drive during read.
- cpu_data_oe  out  1  data-bus output enable, active-high.
- mem_addr  out  15  local memory address.
- mem_wdata  out  8  local write data.
- mem_rd_req  out  1  read request, held until ack.
- mem_wr_req  out  1  write request, held until ack.
- mem_rdata  in  8  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse.
- miss_count  out  MISS_CNT_WIDTH  saturating count of unserviced cycles.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; synchroniser flops 0.
  - Reset mid-transaction drops any request immediately; the memory side must tolerate an abandoned request.
- Synchronisation and edges:
  - m2_s, romsel_s, rw_s and data_s are SYNC_STAGES-delayed copies of the raw inputs.
  - rise = m2_s & !m2_s_prev; fall = !m2_s & m2_s_prev.
- IDLE:
  - On rise, load settle counter with SETTLE_CYCLES-1 and go to SETTLE.
- SETTLE:
  - Decrement the counter each cycle.
  - When it reaches 0 and romsel_s=1: go to WAIT_LOW (cycle not selected).
  - When it reaches 0 and romsel_s=0: latch cpu_addr into mem_addr. Then rw_s=1 goes to READ with mem_rd_req=1; rw_s=0 goes to WRITE_CAP.
  - A fall during SETTLE increments miss_count and returns to IDLE.
- READ:
  - Hold mem_rd_req until mem_ack.
  - On ack with m2_s still high: cpu_data_out<=mem_rdata, cpu_data_oe<=1, mem_rd_req<=0, go to DRIVE.
  - If a fall occurred before ack: still wait for ack, then drop the request, do not drive, increment miss_count, go to IDLE.
- DRIVE:
  - Keep cpu_data_oe high while m2_s is high.
  - After fall, keep it high for HOLD_CYCLES further cycles, then clear cpu_data_oe and go to IDLE.
  - cpu_data_out holds its value after oe drops.
- WRITE_CAP:
  - While m2_s is high, mem_wdata<=data_s every cycle, so the last high-cycle value is retained.
  - On fall: mem_wr_req<=1, go to WRITE_REQ.
- WRITE_REQ:
  - Hold mem_wr_req, mem_addr and mem_wdata until mem_ack, then clear the request and go to IDLE.
- WAIT_LOW:
  - When m2_s is low, go to IDLE.
- Overlap: a rise in any state except IDLE and WAIT_LOW is ignored and increments miss_count. The current transaction always completes.
- miss_count saturates at all-ones; it never wraps.
- mem_rd_req and mem_wr_req are never high together.
- A request rises only on a state entry.
- Read latency: mem_rd_req is high SETTLE_CYCLES+1 cycles after the rise-detect cycle. cpu_data_oe is high the cycle after mem_ack.

Decomposition:
- Package cart_bus_pkg holds:
  - the state enumeration (IDLE, SETTLE, READ, DRIVE, WRITE_CAP, WRITE_REQ, WAIT_LOW);
  - the CPU address width constant (15) and data width constant (8).
- Sub-module bus_sync: a parameterised SYNC_STAGES synchroniser with rise/fall outputs. One instance for m2; plain synchroniser instances for romsel, cpu_rw and data.

Test Plan:
- Read: romsel=0, rw=1, addr=0x1234, M2 high 16 cycles, memory acks 2 cycles after req with 0xA5 → mem_addr=0x1234, single mem_rd_req; cpu_data_out=0xA5, oe high until fall+1; miss_count=0.
- Write: romsel=0, rw=0, addr=0x7FFF, data=0x3C through M2 high, 0xFF after fall → exactly one mem_wr_req with wdata=0x3C, addr=0x7FFF.
- Not selected: romsel=1 for a full M2 cycle → no mem_*_req, oe stays 0, FSM passes through WAIT_LOW back to IDLE.
- Slow memory: ack 20 cycles after req, M2 high 10 cycles → oe never asserted; miss_count=1; FSM back in IDLE after ack.
- Saturation: MISS_CNT_WIDTH=2, 5 consecutive slow reads → miss_count=3.
- Reset: assert reset during WRITE_REQ → next cycle all outputs 0, busy=0; the following good read completes normally.
